// File: rtl/toy_pkg.sv
// Shared definitions for the program loader: FSM states and default widths.
package toy_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W      = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // States in which a stream byte can be taken.
    function automatic logic is_rx(state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/toy_loader_if.sv
// Byte-stream, control and instruction-memory write bundle for toy_loader.
interface toy_loader_if #(
    parameter int ADDR_W = toy_pkg::ADDR_W_DEF,
    parameter int DATA_W = toy_pkg::DATA_W_DEF
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/toy_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// while holding the CPU in reset; releases it only after a good checksum.
module toy_loader
    import toy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic         clk,
    input logic         reset,
    toy_loader_if.slave bus
);

    state_t           state;
    state_t           nxt;
    logic [7:0]       len_hi;
    logic [7:0]       data_hi;
    logic [7:0]       csum;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] index;
    logic [LEN_W-1:0] len_full;
    logic             accept;

    assign accept   = bus.byte_valid & bus.byte_ready;
    assign len_full = {len_hi[3:0], bus.byte_data};

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (bus.start) nxt = S_LEN_HI;
            S_LEN_HI:  if (accept) nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_hi[7:4] != 4'd0)       nxt = S_ERR;
                    else if (len_full == '0)       nxt = S_CHK;
                    else                           nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) nxt = S_DATA_LO;
            S_DATA_LO: if (accept) nxt = (index + 12'd1 == len) ? S_CHK : S_DATA_HI;
            S_CHK:     if (accept) nxt = (bus.byte_data == csum) ? S_DONE : S_ERR;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            len_hi         <= '0;
            data_hi        <= '0;
            csum           <= '0;
            len            <= '0;
            index          <= '0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.cpu_hold   <= 1'b1;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            state          <= nxt;
            bus.byte_ready <= is_rx(nxt);
            bus.done       <= (nxt == S_DONE);
            bus.error      <= (nxt == S_ERR);
            bus.cpu_hold   <= (nxt != S_DONE);
            bus.imem_we    <= 1'b0;

            if (!is_rx(state) && bus.start) begin
                csum  <= '0;
                index <= '0;
            end

            if (accept) begin
                case (state)
                    S_LEN_HI: begin
                        len_hi <= bus.byte_data;
                        csum   <= csum ^ bus.byte_data;
                    end
                    S_LEN_LO: begin
                        len  <= len_full;
                        csum <= csum ^ bus.byte_data;
                    end
                    S_DATA_HI: begin
                        data_hi <= bus.byte_data;
                        csum    <= csum ^ bus.byte_data;
                    end
                    S_DATA_LO: begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= ADDR_W'(index);
                        bus.imem_wdata <= DATA_W'({data_hi, bus.byte_data});
                        index          <= index + 12'd1;
                        csum           <= csum ^ bus.byte_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_toy_loader.sv
// Directed bench for toy_loader: normal, bad checksum, zero/illegal length,
// reset mid-load and gapped stream with a stray start pulse.
module tb_toy_loader;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [31:0] wq[$];

    toy_loader_if bus ();

    toy_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.imem_we === 1'b1)
            wq.push_back({4'b0, bus.imem_addr, bus.imem_wdata});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_error"}, 32'(bus.error), 32'(e));
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        reset          = 1'b1;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(bus.byte_ready), 32'd0);

        // normal load
        pulse_start();
        chk("norm_start_ready", 32'(bus.byte_ready), 32'd1);
        chk("norm_start_hold", 32'(bus.cpu_hold), 32'd1);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        send_byte(8'h42, 0);
        chk_status("norm", 1'b1, 1'b0, 1'b0);
        chk("norm_nwr", 32'(wq.size()), 32'd2);
        chk("norm_wr0", wq[0], 32'h0000_1234);
        chk("norm_wr1", wq[1], 32'h0001_ABCD);
        wq.delete();

        // bad checksum, also a restart from S_DONE
        pulse_start();
        chk("bad_restart_done", 32'(bus.done), 32'd0);
        chk("bad_restart_hold", 32'(bus.cpu_hold), 32'd1);
        chk("bad_restart_ready", 32'(bus.byte_ready), 32'd1);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        send_byte(8'h43, 0);
        chk_status("bad", 1'b0, 1'b1, 1'b1);
        chk("bad_nwr", 32'(wq.size()), 32'd2);
        chk("bad_wr0", wq[0], 32'h0000_1234);
        chk("bad_wr1", wq[1], 32'h0001_ABCD);
        wq.delete();

        // zero length
        pulse_start();
        chk("zero_restart_error", 32'(bus.error), 32'd0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk_status("zero", 1'b1, 1'b0, 1'b0);
        chk("zero_nwr", 32'(wq.size()), 32'd0);

        // illegal length: upper nibble of LEN_HI set
        pulse_start();
        send_byte(8'h10, 0); send_byte(8'h00, 0);
        chk_status("illegal", 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("illegal_nwr", 32'(wq.size()), 32'd0);

        // reset after the first word, then a fresh load
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_nwr", 32'(wq.size()), 32'd1);
        chk("midrst_wr0", wq[0], 32'h0000_1234);
        chk_status("midrst", 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_after_nwr", 32'(wq.size()), 32'd1);
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        send_byte(8'h50, 0);
        chk_status("reload", 1'b1, 1'b0, 1'b0);
        chk("reload_nwr", 32'(wq.size()), 32'd1);
        chk("reload_wr0", wq[0], 32'h0000_BEEF);
        wq.delete();

        // gapped stream with a stray start pulse mid-load
        pulse_start();
        send_byte(8'h00, 3); send_byte(8'h02, 1);
        send_byte(8'h12, 2);
        pulse_start();
        chk("gap_start_ignored_ready", 32'(bus.byte_ready), 32'd1);
        send_byte(8'h34, 4); send_byte(8'hAB, 1);
        send_byte(8'hCD, 2); send_byte(8'h42, 3);
        chk_status("gap", 1'b1, 1'b0, 1'b0);
        chk("gap_nwr", 32'(wq.size()), 32'd2);
        chk("gap_wr0", wq[0], 32'h0000_1234);
        chk("gap_wr1", wq[1], 32'h0001_ABCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
